// File: rtl/mpsoc_mpi_pkg.sv
// Shared definitions for the MPI endpoint network side: flit type encodings
// and the terminal-flit helper used to find packet boundaries.
package mpsoc_mpi_pkg;

  typedef enum logic [1:0] {
    FLIT_TYPE_PAYLOAD = 2'b00,
    FLIT_TYPE_HEADER  = 2'b01,
    FLIT_TYPE_LAST    = 2'b10,
    FLIT_TYPE_SINGLE  = 2'b11
  } flit_type_e;

  // A packet ends on its LAST flit, or is a single self-contained flit.
  function automatic logic is_terminal(input logic [1:0] flit_type);
    return (flit_type == FLIT_TYPE_LAST) || (flit_type == FLIT_TYPE_SINGLE);
  endfunction

endpackage

// File: rtl/mpsoc_mpi_packet_buffer_if.sv
// Router-side and endpoint-side flit streams of the MPI packet buffer.
// The buffer uses the slave modport; whoever drives the router side and
// consumes the endpoint side uses the master modport.
interface mpsoc_mpi_packet_buffer_if #(
  parameter int NoC_DATA_WIDTH = 32,
  parameter int NoC_TYPE_WIDTH = 2,
  parameter int FIFO_DEPTH     = 16,
  parameter int NoC_FLIT_WIDTH = NoC_DATA_WIDTH + NoC_TYPE_WIDTH,
  parameter int SIZE_WIDTH     = $clog2(FIFO_DEPTH + 1)
);

  logic [NoC_FLIT_WIDTH-1:0] in_flit;
  logic                      in_valid;
  logic                      in_ready;
  logic [NoC_FLIT_WIDTH-1:0] out_flit;
  logic                      out_valid;
  logic                      out_ready;
  logic [SIZE_WIDTH-1:0]     out_size;

  modport master (
    output in_flit,
    output in_valid,
    input  in_ready,
    input  out_flit,
    input  out_valid,
    output out_ready,
    input  out_size
  );

  modport slave (
    input  in_flit,
    input  in_valid,
    output in_ready,
    output out_flit,
    output out_valid,
    input  out_ready,
    output out_size
  );

endinterface

// File: rtl/mpsoc_mpi_fifo.sv
// Generic synchronous FIFO with an occupancy counter and a combinational
// head read. DEPTH must be a power of two so the pointers wrap naturally.
module mpsoc_mpi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push & !o_full;
  assign w_doPop  = i_pop & !o_empty;
  assign o_data   = r_mem[r_rdPtr];

  // Storage is not reset; the occupancy counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mpsoc_mpi_packet_buffer.sv
// Store-and-forward flit buffer between a NoC router port and an MPI endpoint,
// with cut-through fallback for packets longer than the buffer.
// Define MPSOC_MPI_PACKET_SIZE_EN to report the head packet length on out_size.
module mpsoc_mpi_packet_buffer
  import mpsoc_mpi_pkg::*;
#(
  parameter int NoC_DATA_WIDTH = 32,
  parameter int NoC_TYPE_WIDTH = 2,
  parameter int FIFO_DEPTH     = 16,
  parameter int NoC_FLIT_WIDTH = NoC_DATA_WIDTH + NoC_TYPE_WIDTH,
  parameter int SIZE_WIDTH     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  mpsoc_mpi_packet_buffer_if.slave    bus
);

  logic [NoC_FLIT_WIDTH-1:0] w_head;
  logic [NoC_TYPE_WIDTH-1:0] w_inType;
  logic [NoC_TYPE_WIDTH-1:0] w_outType;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_inReady;
  logic                      w_outValid;
  logic                      w_wr;
  logic                      w_rd;
  logic                      w_inTerm;
  logic                      w_outTerm;
  logic                      w_cutSet;
  logic                      w_cut;
  logic [SIZE_WIDTH-1:0]     r_pktCnt;
  logic                      r_cut;

  assign w_inType  = bus.in_flit[NoC_FLIT_WIDTH-1 -: NoC_TYPE_WIDTH];
  assign w_outType = w_head[NoC_FLIT_WIDTH-1 -: NoC_TYPE_WIDTH];
  assign w_inTerm  = is_terminal(w_inType);
  assign w_outTerm = is_terminal(w_outType);

  assign w_inReady = !w_full & !rst;
  assign w_wr      = bus.in_valid & w_inReady;
  assign w_rd      = w_outValid & bus.out_ready;

  // A full buffer holding no complete packet can only be one oversized packet;
  // forwarding it immediately keeps the network from deadlocking.
  assign w_cutSet   = w_full & (r_pktCnt == '0);
  assign w_cut      = r_cut | w_cutSet;
  assign w_outValid = !w_empty & ((r_pktCnt != '0) | w_cut);

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_flit  = w_outValid ? w_head : '0;

  mpsoc_mpi_fifo #(
    .WIDTH (NoC_FLIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_flitFifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr),
    .i_pop   (w_rd),
    .i_data  (bus.in_flit),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pktCnt <= '0;
    end else begin
      case ({w_wr & w_inTerm, w_rd & w_outTerm})
        2'b10:   r_pktCnt <= r_pktCnt + SIZE_WIDTH'(1);
        2'b01:   r_pktCnt <= r_pktCnt - SIZE_WIDTH'(1);
        default: r_pktCnt <= r_pktCnt;
      endcase
    end
  end

  // Cut-through lasts until the oversized packet's terminal flit leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cut <= 1'b0;
    end else if (w_rd & w_outTerm) begin
      r_cut <= 1'b0;
    end else if (w_cutSet) begin
      r_cut <= 1'b1;
    end
  end

`ifdef MPSOC_MPI_PACKET_SIZE_EN
  localparam int LEN_W = SIZE_WIDTH + 1;

  logic [LEN_W-1:0]      r_lenCnt;
  logic [LEN_W-1:0]      w_pktLen;
  logic [SIZE_WIDTH-1:0] w_sizeHead;
  logic                  w_sizePush;
  logic                  w_sizePop;
  logic                  w_sizeFull;
  logic                  w_sizeEmpty;

  assign w_pktLen   = r_lenCnt + LEN_W'(1);
  assign w_sizePush = w_wr & w_inTerm & !w_sizeFull & (w_pktLen <= LEN_W'(FIFO_DEPTH));
  assign w_sizePop  = w_rd & w_outTerm & !w_cut;

  // Saturates just above the buffer depth; anything that long is cut-through.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lenCnt <= '0;
    end else if (w_wr) begin
      if (w_inTerm) begin
        r_lenCnt <= '0;
      end else if (r_lenCnt <= LEN_W'(FIFO_DEPTH)) begin
        r_lenCnt <= r_lenCnt + LEN_W'(1);
      end
    end
  end

  mpsoc_mpi_fifo #(
    .WIDTH (SIZE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_sizeFifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_sizePush),
    .i_pop   (w_sizePop),
    .i_data  (w_pktLen[SIZE_WIDTH-1:0]),
    .o_data  (w_sizeHead),
    .o_full  (w_sizeFull),
    .o_empty (w_sizeEmpty)
  );

  assign bus.out_size = (w_outValid & !w_cut & !w_sizeEmpty) ? w_sizeHead : '0;
`else
  assign bus.out_size = '0;
`endif

endmodule

// File: tb/tb_mpsoc_mpi_packet_buffer.sv
// Directed self-checking bench for mpsoc_mpi_packet_buffer: store-and-forward,
// back-pressure, cut-through, same-cycle packet accounting and mid-packet reset.
module tb_mpsoc_mpi_packet_buffer;
  import mpsoc_mpi_pkg::*;

  localparam int DW    = 32;
  localparam int TW    = 2;
  localparam int DEPTH = 16;
  localparam int FW    = DW + TW;
  localparam int SW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mpsoc_mpi_packet_buffer_if #(
    .NoC_DATA_WIDTH (DW),
    .NoC_TYPE_WIDTH (TW),
    .FIFO_DEPTH     (DEPTH)
  ) io ();

  mpsoc_mpi_packet_buffer #(
    .NoC_DATA_WIDTH (DW),
    .NoC_TYPE_WIDTH (TW),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (io.slave)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [FW-1:0] mkFlit(input flit_type_e t, input logic [31:0] d);
    return {t, d};
  endfunction

  function automatic logic [SW-1:0] expSize(input int n);
`ifdef MPSOC_MPI_PACKET_SIZE_EN
    return SW'(n);
`else
    return SW'(n * 0);
`endif
  endfunction

  function automatic flit_type_e pktType(input int idx, input int len);
    if (len == 1) return FLIT_TYPE_SINGLE;
    if (idx == 0) return FLIT_TYPE_HEADER;
    if (idx == len - 1) return FLIT_TYPE_LAST;
    return FLIT_TYPE_PAYLOAD;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one flit and holds it until the buffer takes it (bounded wait).
  task automatic applyStimulus(input logic [FW-1:0] f);
    int waited = 0;
    io.in_flit  = f;
    io.in_valid = 1'b1;
    while (!io.in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!io.in_ready) checkOutput("inReadyTimeout", 64'(io.in_ready), 64'(1));
    step();
    io.in_valid = 1'b0;
    io.in_flit  = '0;
  endtask

  task automatic expectFlit(input string tag, input logic [FW-1:0] f, input int sz);
    checkOutput({tag, ".valid"}, 64'(io.out_valid), 64'(1));
    checkOutput({tag, ".flit"}, 64'(io.out_flit), 64'(f));
    checkOutput({tag, ".size"}, 64'(io.out_size), 64'(expSize(sz)));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    io.in_flit   = '0;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    checkOutput("rst.inReady", 64'(io.in_ready), 64'(0));
    checkOutput("rst.outValid", 64'(io.out_valid), 64'(0));
    checkOutput("rst.outFlit", 64'(io.out_flit), 64'(0));
    checkOutput("rst.outSize", 64'(io.out_size), 64'(0));
    rst = 1'b0;
    step();
    checkOutput("idle.inReady", 64'(io.in_ready), 64'(1));
    checkOutput("idle.outValid", 64'(io.out_valid), 64'(0));

    // Three-flit packet is held back until its LAST flit is stored
    io.out_ready = 1'b1;
    applyStimulus(mkFlit(FLIT_TYPE_HEADER, 32'h1));
    checkOutput("p3.afterH", 64'(io.out_valid), 64'(0));
    applyStimulus(mkFlit(FLIT_TYPE_PAYLOAD, 32'h2));
    checkOutput("p3.afterP", 64'(io.out_valid), 64'(0));
    applyStimulus(mkFlit(FLIT_TYPE_LAST, 32'h3));
    expectFlit("p3.f0", mkFlit(FLIT_TYPE_HEADER, 32'h1), 3);
    step();
    expectFlit("p3.f1", mkFlit(FLIT_TYPE_PAYLOAD, 32'h2), 3);
    step();
    expectFlit("p3.f2", mkFlit(FLIT_TYPE_LAST, 32'h3), 3);
    step();
    checkOutput("p3.done", 64'(io.out_valid), 64'(0));

    applyStimulus(mkFlit(FLIT_TYPE_SINGLE, 32'hAB));
    expectFlit("single", mkFlit(FLIT_TYPE_SINGLE, 32'hAB), 1);
    step();
    checkOutput("single.done", 64'(io.out_valid), 64'(0));

    // Terminal write and terminal read in the same cycle
    applyStimulus(mkFlit(FLIT_TYPE_SINGLE, 32'h11));
    expectFlit("same.a", mkFlit(FLIT_TYPE_SINGLE, 32'h11), 1);
    io.in_flit  = mkFlit(FLIT_TYPE_SINGLE, 32'h22);
    io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    io.in_flit  = '0;
    expectFlit("same.b", mkFlit(FLIT_TYPE_SINGLE, 32'h22), 1);
    step();
    checkOutput("same.done", 64'(io.out_valid), 64'(0));

    // Fill with four 4-flit packets while the endpoint stalls
    io.out_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int f = 0; f < 4; f++) begin
        applyStimulus(mkFlit(pktType(f, 4), 32'(p * 16 + f)));
      end
    end
    checkOutput("full.inReady", 64'(io.in_ready), 64'(0));
    expectFlit("full.head", mkFlit(FLIT_TYPE_HEADER, 32'h0), 4);
    io.in_flit  = mkFlit(FLIT_TYPE_SINGLE, 32'hFF);
    io.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("hold.inReady", 64'(io.in_ready), 64'(0));
      expectFlit("hold", mkFlit(FLIT_TYPE_HEADER, 32'h0), 4);
    end
    io.in_valid  = 1'b0;
    io.in_flit   = '0;
    io.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expectFlit($sformatf("drain%0d", i), mkFlit(pktType(i % 4, 4), 32'((i / 4) * 16 + (i % 4))), 4);
      step();
    end
    checkOutput("drain.done", 64'(io.out_valid), 64'(0));
    checkOutput("drain.inReady", 64'(io.in_ready), 64'(1));

    // Oversized 20-flit packet falls back to cut-through
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          applyStimulus(mkFlit(pktType(i, 20), 32'h100 + 32'(i)));
        end
      end
      begin
        int got  = 0;
        int idle = 0;
        int cyc  = 0;
        while (got < 20 && cyc < 200) begin
          if (io.out_valid) begin
            if (got == 0) checkOutput("cut.entry", 64'(idle), 64'(16));
            checkOutput($sformatf("cut.flit%0d", got), 64'(io.out_flit), 64'(mkFlit(pktType(got, 20), 32'h100 + 32'(got))));
            checkOutput($sformatf("cut.size%0d", got), 64'(io.out_size), 64'(0));
            got++;
          end else if (got == 0) begin
            idle++;
          end
          step();
          cyc++;
        end
        checkOutput("cut.delivered", 64'(got), 64'(20));
      end
    join
    checkOutput("cut.done", 64'(io.out_valid), 64'(0));
    applyStimulus(mkFlit(FLIT_TYPE_HEADER, 32'h201));
    checkOutput("post.afterH", 64'(io.out_valid), 64'(0));
    applyStimulus(mkFlit(FLIT_TYPE_LAST, 32'h202));
    expectFlit("post.f0", mkFlit(FLIT_TYPE_HEADER, 32'h201), 2);
    step();
    expectFlit("post.f1", mkFlit(FLIT_TYPE_LAST, 32'h202), 2);
    step();
    checkOutput("post.done", 64'(io.out_valid), 64'(0));

    // Reset with five flits of an unfinished packet stored
    applyStimulus(mkFlit(FLIT_TYPE_HEADER, 32'h301));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mkFlit(FLIT_TYPE_PAYLOAD, 32'h302 + 32'(i)));
    end
    checkOutput("rstmid.pending", 64'(io.out_valid), 64'(0));
    rst = 1'b1;
    step();
    checkOutput("rstmid.inReady", 64'(io.in_ready), 64'(0));
    checkOutput("rstmid.outValid", 64'(io.out_valid), 64'(0));
    rst = 1'b0;
    step();
    checkOutput("rstmid.inReadyAfter", 64'(io.in_ready), 64'(1));
    checkOutput("rstmid.outValidAfter", 64'(io.out_valid), 64'(0));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkFlit(pktType(i, 3), 32'h401 + 32'(i)));
    end
    for (int i = 0; i < 3; i++) begin
      expectFlit($sformatf("rstmid.f%0d", i), mkFlit(pktType(i, 3), 32'h401 + 32'(i)), 3);
      step();
    end
    checkOutput("rstmid.done", 64'(io.out_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
